mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-master arbiter sharing the single unified memory port of the `riscv` pipeline between the instruction-fetch stage and the data-memory (load/store) stage. Only one transaction is in flight at a time. Data accesses have priority, with a starvation guard for fetch. Sits between the pipeline's IF/MEM stages and the memory model.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (≥1)
- TIMEOUT, 64, cycles allowed from m_req assertion to m_rvalid (≥2; used only with MEM_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted (one-cycle pulse)
- i_rvalid  out  1  fetch data valid (one-cycle pulse)
- i_rdata  out  DATA_W  fetch data
- i_err  out  1  fetch aborted (qualifies i_rvalid)
- d_req  in  1  data request; held with its payload stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_gnt  out  1  data request accepted (one-cycle pulse)
- d_rvalid  out  1  load data / store completion valid (one-cycle pulse)
- d_rdata  out  DATA_W  load data; 0 on stores
- d_err  out  1  data access aborted (qualifies d_rvalid)
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_be  out  DATA_W/8  memory byte enables
- m_gnt  in  1  memory accepted m_req this cycle
- m_rvalid  in  1  memory response (read data or write completion)
- m_rdata  in  DATA_W  memory read data
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: if any request is pending, pick the winner. Data wins unless starve_cnt == STARVE_MAX and i_req=1; then fetch wins.
  - The winner's gnt is driven combinationally in IDLE.
  - At the clock edge, latch the winner's payload into m_* and record the owner; fetch latches m_we=0 and m_be all ones.
  - Go to REQ.
- REQ: m_req=1 with stable payload. Go to WAIT on the edge where m_gnt=1.
- WAIT: m_req=0. On the edge where m_rvalid=1:
  - Register the owner's rvalid=1; rdata=m_rdata (data stores: 0).
  - Return to IDLE.
- m_rvalid is ignored in IDLE and REQ.
- starve_cnt (saturating at STARVE_MAX):
  - increments on each data grant while i_req=1;
  - clears on a fetch grant;
  - holds otherwise.
- Non-owner rvalid/err stay 0; rdata holds its last value.
- Reset (any time, including mid-transaction): state IDLE, starve_cnt 0, timeout counter 0. All outputs 0: m_*, gnt, rvalid, rdata, err, busy. The in-flight transaction is discarded; requesters reissue.

## Timing
- Request in cycle 0 with the arbiter in IDLE: gnt in cycle 0, m_req from cycle 1.
- Zero-wait memory (m_gnt in cycle 1, m_rvalid in cycle 2): rvalid in cycle 3.
- Minimum latency is 3 cycles req→rvalid. Each extra m_gnt or m_rvalid wait cycle adds one.
- The arbiter is in IDLE again in the rvalid cycle. The next grant can occur in that same cycle, giving a 3-cycle issue interval per transaction.
- m_rvalid coincident with m_gnt (same cycle) is a protocol violation and is not observed.
- Simultaneous i_req and d_req: exactly one gnt per IDLE cycle, never both.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter runs from entry to REQ.
  - If m_rvalid has not been sampled after TIMEOUT cycles, drop m_req and return to IDLE.
  - Pulse the owner's rvalid=1, err=1, rdata=0.
  - Memory must not respond to an aborted transaction.
- Not defined: the arbiter waits indefinitely; i_err and d_err are constant 0 and no timeout counter exists.

## Test plan
- Lone load: d_req, d_addr=0x40, memory returns 0xDEADBEEF with zero wait → d_gnt cycle 0, m_req cycle 1, d_rvalid/d_rdata=0xDEADBEEF cycle 3, i_* silent.
- Simultaneous i_req and d_req held continuously, zero-wait memory, STARVE_MAX=4 → grant sequence D,D,D,D,I,D,D,D,D,I; never both gnts in one cycle.
- Store d_we=1, d_be=4'b0011, d_wdata=0x1234 with m_gnt delayed 2 cycles → m_req held stable for 3 cycles, d_rvalid=1, d_rdata=0, d_err=0.
- Reset asserted in WAIT → all outputs 0 asynchronously, busy=0. After release, a late m_rvalid produces no rvalid, and a new i_req is granted normally.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=8, memory never responds to a fetch → m_req drops, i_rvalid=1 with i_err=1 and i_rdata=0 after 8 cycles in REQ/WAIT; the following d_req is granted.
- Macro undefined, same stall for 200 cycles → busy stays 1, i_err never asserts, completion occurs when m_rvalid finally arrives.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the unified memory port: data (load/store) wins, fetch gets a turn after
// STARVE_MAX consecutive data grants. Define MEM_ARB_TIMEOUT_EN to abort transactions memory never answers.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);

    if (STARVE_MAX < 1 || TIMEOUT < 2 || (DATA_W % 8) != 0) begin : g_param_check
        $error("mem_port_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            owner_data;
    logic [SC_W-1:0] starve_cnt;
    logic            fetch_wins;
    logic            complete;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             abort;
`endif

    // Fetch only beats a pending data request once the starvation counter has saturated.
    assign fetch_wins = i_req && (!d_req || starve_cnt == STARVE_TOP);
    assign i_gnt      = (state == IDLE) && !reset && fetch_wins;
    assign d_gnt      = (state == IDLE) && !reset && d_req && !fetch_wins;
    assign m_req      = (state == REQ);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        abort     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (i_gnt || d_gnt) state_nxt = REQ;
            end
            REQ: begin
                if (m_gnt) state_nxt = WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                if (tmo_hit) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
`endif
            end
            WAIT: begin
                if (m_rvalid) begin
                    state_nxt = IDLE;
                    complete  = 1'b1;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_data <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= '0;
            starve_cnt <= '0;
            i_rvalid   <= 1'b0;
            i_rdata    <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (i_gnt) begin
                owner_data <= 1'b0;
                m_we       <= 1'b0;
                m_addr     <= i_addr;
                m_wdata    <= '0;
                m_be       <= '1;
                starve_cnt <= '0;
            end
            if (d_gnt) begin
                owner_data <= 1'b1;
                m_we       <= d_we;
                m_addr     <= d_addr;
                m_wdata    <= d_wdata;
                m_be       <= d_be;
                if (i_req && starve_cnt != STARVE_TOP) starve_cnt <= starve_cnt + 1'b1;
            end
            // Stores complete with zero data so the pipeline never sees stale read data.
            if (complete) begin
                if (owner_data) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= m_we ? '0 : m_rdata;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= m_rdata;
                end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            if (abort) begin
                if (owner_data) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= '0;
                end else begin
                    i_rvalid <= 1'b1;
                    i_rdata  <= '0;
                end
            end
`endif
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Counts cycles spent in REQ/WAIT; the abort fires after TIMEOUT of them.
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              tmo_cnt <= '0;
        else if (state == IDLE) tmo_cnt <= '0;
        else                    tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_err <= 1'b0;
            d_err <= 1'b0;
        end else begin
            i_err <= abort && !owner_data;
            d_err <= abort && owner_data;
        end
    end
`else
    assign i_err = 1'b0;
    assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for starvation, reset mid-transaction and a stalled memory.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt, i_rvalid, i_err;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req, d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt, d_rvalid, d_err;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_be;
    logic              m_gnt, m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gnt_wait;
        int          rv_wait;
        logic [31:0] mem_rdata;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } txn_t;

    txn_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction starting in an IDLE cycle; leaves the bench one cycle past rvalid.
    task automatic run_txn(input txn_t t);
        i_req   = !t.is_d;
        i_addr  = t.addr;
        d_req   = t.is_d;
        d_we    = t.we;
        d_addr  = t.addr;
        d_wdata = t.wdata;
        d_be    = t.be;
        @(negedge clk);
        chk({t.name, ".gnt_owner"}, t.is_d ? d_gnt : i_gnt, 1);
        chk({t.name, ".gnt_other"}, t.is_d ? i_gnt : d_gnt, 0);
        chk({t.name, ".mreq_c0"}, m_req, 0);
        step();
        i_req   = 1'b0;
        d_req   = 1'b0;
        i_addr  = ~t.addr;
        d_addr  = ~t.addr;
        d_wdata = ~t.wdata;
        d_we    = ~t.we;
        d_be    = ~t.be;
        for (int k = 0; k <= t.gnt_wait; k++) begin
            m_gnt = (k == t.gnt_wait);
            @(negedge clk);
            chk($sformatf("%s.mreq_%0d", t.name, k), m_req, 1);
            chk($sformatf("%s.maddr_%0d", t.name, k), m_addr, t.addr);
            chk($sformatf("%s.mwe_%0d", t.name, k), m_we, t.exp_we);
            chk($sformatf("%s.mbe_%0d", t.name, k), m_be, t.exp_be);
            if (t.is_d) chk($sformatf("%s.mwdata_%0d", t.name, k), m_wdata, t.wdata);
            step();
        end
        m_gnt = 1'b0;
        for (int k = 0; k <= t.rv_wait; k++) begin
            m_rvalid = (k == t.rv_wait);
            m_rdata  = (k == t.rv_wait) ? t.mem_rdata : 32'hBAD0_BAD0;
            @(negedge clk);
            chk($sformatf("%s.wait_mreq_%0d", t.name, k), m_req, 0);
            chk($sformatf("%s.wait_busy_%0d", t.name, k), busy, 1);
            step();
        end
        m_rvalid = 1'b0;
        @(negedge clk);
        chk({t.name, ".rvalid"}, t.is_d ? d_rvalid : i_rvalid, 1);
        chk({t.name, ".rdata"}, t.is_d ? d_rdata : i_rdata, t.exp_rdata);
        chk({t.name, ".err"}, t.is_d ? d_err : i_err, 0);
        chk({t.name, ".other_rvalid"}, t.is_d ? i_rvalid : d_rvalid, 0);
        chk({t.name, ".busy_end"}, busy, 0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        byte   exp_seq[10];
        byte   got_seq[10];
        int    n;
        int    both;
        int    bad;
        int    cyc;
        bit    found;
        txn_t  t;

        tbl[0] = '{"load40", 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF, 1'b0, 4'hF, 32'hDEADBEEF};
        tbl[1] = '{"store80", 1'b1, 1'b1, 32'h80, 32'h1234, 4'b0011, 2, 0, 32'h5555_5555, 1'b1, 4'b0011, 32'h0};
        tbl[2] = '{"fetch100", 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1, 1, 32'h0000_0013, 1'b0, 4'hF, 32'h0000_0013};
        tbl[3] = '{"load44", 1'b1, 1'b0, 32'h44, 32'h0, 4'b1100, 0, 2, 32'hA5A5_5A5A, 1'b0, 4'b1100, 32'hA5A5_5A5A};
        exp_seq = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};

        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.m_req", m_req, 0);
        chk("rst.i_rvalid", i_rvalid, 0);
        chk("rst.d_rvalid", d_rvalid, 0);
        chk("rst.m_addr", m_addr, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 4; i++) run_txn(tbl[i]);

        // Both masters requesting continuously against a zero-wait memory.
        i_req = 1'b1; i_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
        n = 0; both = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            m_gnt    = m_req;
            m_rvalid = busy && !m_req;
            m_rdata  = 32'h1000 + c;
            @(negedge clk);
            if (i_gnt && d_gnt) both++;
            if (i_gnt || d_gnt) begin
                got_seq[n] = d_gnt ? "D" : "I";
                n++;
            end
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("starve.grants", n, 10);
        chk("starve.both_gnt", both, 0);
        for (int i = 0; i < 10; i++) chk($sformatf("starve.g%0d", i), got_seq[i], exp_seq[i]);
        for (int c = 0; c < 10 && busy; c++) begin
            m_gnt    = m_req;
            m_rvalid = busy && !m_req;
            step();
        end
        m_gnt = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        chk("starve.drained", busy, 0);
        step();

        // Reset while waiting for the memory response.
        i_req = 1'b1; i_addr = 32'h500;
        @(negedge clk);
        chk("rstw.gnt", i_gnt, 1);
        step();
        i_req = 1'b0; m_gnt = 1'b1;
        @(negedge clk);
        chk("rstw.mreq", m_req, 1);
        step();
        m_gnt = 1'b0;
        @(negedge clk);
        chk("rstw.busy_wait", busy, 1);
        #2;
        reset = 1'b1; i_req = 1'b1; d_req = 1'b1;
        #1;
        chk("rstw.busy", busy, 0);
        chk("rstw.m_req", m_req, 0);
        chk("rstw.m_addr", m_addr, 0);
        chk("rstw.m_be", m_be, 0);
        chk("rstw.m_we", m_we, 0);
        chk("rstw.m_wdata", m_wdata, 0);
        chk("rstw.i_gnt", i_gnt, 0);
        chk("rstw.d_gnt", d_gnt, 0);
        chk("rstw.i_rdata", i_rdata, 0);
        chk("rstw.d_rdata", d_rdata, 0);
        chk("rstw.rvalid", {i_rvalid, d_rvalid, i_err, d_err}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("rstw.idle_after", busy, 0);
        step();
        m_rvalid = 1'b0;
        @(negedge clk);
        chk("rstw.late_rvalid", {i_rvalid, d_rvalid}, 0);
        step();
        t = '{"fetch600", 1'b0, 1'b0, 32'h600, 32'h0, 4'h0, 0, 0, 32'h1111_2222, 1'b0, 4'hF, 32'h1111_2222};
        run_txn(t);

        // Fetch whose response never comes (or comes very late).
        i_req = 1'b1; i_addr = 32'h700;
        @(negedge clk);
        chk("stall.gnt", i_gnt, 1);
        step();
        i_req = 1'b0; m_gnt = 1'b1;
        @(negedge clk);
        chk("stall.mreq", m_req, 1);
        step();
        m_gnt = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cyc = 2; found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (i_rvalid) found = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        chk("tmo.found", found, 1);
        chk("tmo.cycle", cyc, 9);
        chk("tmo.err", i_err, 1);
        chk("tmo.rdata", i_rdata, 0);
        chk("tmo.mreq", m_req, 0);
        chk("tmo.busy", busy, 0);
        chk("tmo.d_rvalid", d_rvalid, 0);
        step();
        t = '{"load_after_tmo", 1'b1, 1'b0, 32'h48, 32'h0, 4'hF, 0, 0, 32'h7777_8888, 1'b0, 4'hF, 32'h7777_8888};
        run_txn(t);
`else
        bad = 0; cyc = 0; found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy || i_err || i_rvalid || m_req) bad++;
            step();
        end
        chk("stall.held", bad, 0);
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
        step();
        m_rvalid = 1'b0;
        @(negedge clk);
        chk("stall.rvalid", i_rvalid, 1);
        chk("stall.rdata", i_rdata, 32'hCAFE_F00D);
        chk("stall.err", i_err, 0);
        chk("stall.busy", busy, 0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
